// File: rtl/alu_issue_arbiter.sv
// Two-lane ALU issue arbiter: alternates between lanes on a tie, holds off
// issue while a multiply occupies the ALU, and drops ops that are not one-hot.
module alu_issue_arbiter #(
  parameter int MUL_BUSY = 3,
  parameter int BW       = 66
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          req0_valid,
  input  logic [BW-1:0] req0_bundle,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [BW-1:0] req1_bundle,
  output logic          req1_ready,
  output logic          alu_valid,
  output logic [BW-1:0] alu_bundle,
  output logic          alu_grant_id,
  output logic          illegal_op
);

  typedef enum logic {RUN, MUL_WAIT} state_e;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_BUSY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          alu_valid_q, alu_valid_d;
  logic [BW-1:0] alu_bundle_q, alu_bundle_d;
  logic          alu_grant_id_q, alu_grant_id_d;
  logic          illegal_q, illegal_d;

  logic          grant_en;
  logic          grant_lane;
  logic          xfer;
  logic [BW-1:0] sel_bundle;
  logic [11:0]   sig;
  logic          legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      last_grant_q   <= 1'b1;
      alu_valid_q    <= 1'b0;
      alu_bundle_q   <= '0;
      alu_grant_id_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      alu_valid_q    <= alu_valid_d;
      alu_bundle_q   <= alu_bundle_d;
      alu_grant_id_q <= alu_grant_id_d;
      illegal_q      <= illegal_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    alu_valid_d    = 1'b0;
    alu_bundle_d   = alu_bundle_q;
    alu_grant_id_d = alu_grant_id_q;
    illegal_d      = 1'b0;

    // On a tie the lane that did not win last time gets the slot.
    grant_en   = !reset && !flush && (state_q == RUN);
    grant_lane = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    xfer       = grant_en && (req0_valid || req1_valid);
    req0_ready = xfer && !grant_lane;
    req1_ready = xfer && grant_lane;

    sel_bundle = grant_lane ? req1_bundle : req0_bundle;
    sig        = sel_bundle[11:0];
    legal      = (sig != 12'd0) && ((sig & (sig - 12'd1)) == 12'd0);

    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == MUL_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q <= 4'd1) begin
        state_d = RUN;
      end
    end else if (xfer) begin
      last_grant_d = grant_lane;
      if (legal) begin
        alu_valid_d    = 1'b1;
        alu_bundle_d   = sel_bundle;
        alu_grant_id_d = grant_lane;
        if (sig[4] && (MUL_BUSY > 1)) begin
          state_d = MUL_WAIT;
          cnt_d   = MUL_LOAD;
        end
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  assign alu_valid    = alu_valid_q;
  assign alu_bundle   = alu_bundle_q;
  assign alu_grant_id = alu_grant_id_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed vector table, a hand-written mul/flush
// corner sequence, then random traffic checked against a cycle-count model.
module tb_alu_issue_arbiter;

  localparam int BW       = 66;
  localparam int MUL_BUSY = 3;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          req0_valid;
  logic [BW-1:0] req0_bundle;
  logic          req0_ready;
  logic          req1_valid;
  logic [BW-1:0] req1_bundle;
  logic          req1_ready;
  logic          alu_valid;
  logic [BW-1:0] alu_bundle;
  logic          alu_grant_id;
  logic          illegal_op;

  alu_issue_arbiter #(.MUL_BUSY(MUL_BUSY), .BW(BW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .req0_valid  (req0_valid),
    .req0_bundle (req0_bundle),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_bundle (req1_bundle),
    .req1_ready  (req1_ready),
    .alu_valid   (alu_valid),
    .alu_bundle  (alu_bundle),
    .alu_grant_id(alu_grant_id),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, v0, v1;
    logic [11:0] s0, s1;
    logic        r0, r1, val, id, ill;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Model state: grants are allowed once the cycle index reaches nextOk.
  int            cyc        = 0;
  int            nextOk     = 0;
  int            lastGrant  = 1;
  logic          mR0, mR1, mValid, mIll, mId;
  logic [BW-1:0] mBundle = '0;

  logic          gotR0, gotR1;

  function automatic logic [BW-1:0] mkBundle(input logic [53:0] upper, input logic [11:0] s);
    return {upper, s};
  endfunction

  function automatic int countOnes(input logic [11:0] s);
    int n = 0;
    for (int k = 0; k < 12; k++) n += int'(s[k]);
    return n;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic fl,
                               input logic v0, input logic [BW-1:0] b0,
                               input logic v1, input logic [BW-1:0] b1);
    int            lane;
    logic [BW-1:0] gb;
    logic [11:0]   gs;
    reset = rst; flush = fl;
    req0_valid = v0; req0_bundle = b0;
    req1_valid = v1; req1_bundle = b1;
    #1;
    gotR0 = req0_ready;
    gotR1 = req1_ready;
    lane = -1;
    if (!rst && !fl && cyc >= nextOk) begin
      if (v0 && v1) lane = 1 - lastGrant;
      else if (v0)  lane = 0;
      else if (v1)  lane = 1;
    end
    mR0 = (lane == 0);
    mR1 = (lane == 1);
    @(posedge clk);
    #1;
    mValid = 1'b0;
    mIll   = 1'b0;
    if (rst) begin
      mBundle   = '0;
      mId       = 1'b0;
      lastGrant = 1;
      nextOk    = cyc + 1;
    end else begin
      if (fl) nextOk = cyc + 1;
      if (lane >= 0) begin
        gb = (lane == 1) ? b1 : b0;
        gs = gb[11:0];
        lastGrant = lane;
        if (countOnes(gs) == 1) begin
          mValid  = 1'b1;
          mBundle = gb;
          mId     = (lane == 1);
          if (gs[4]) nextOk = cyc + MUL_BUSY;
        end else begin
          mIll = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".req0_ready"},   BW'(gotR0),        BW'(mR0));
    check({tag, ".req1_ready"},   BW'(gotR1),        BW'(mR1));
    check({tag, ".alu_valid"},    BW'(alu_valid),    BW'(mValid));
    check({tag, ".illegal_op"},   BW'(illegal_op),   BW'(mIll));
    check({tag, ".alu_grant_id"}, BW'(alu_grant_id), BW'(mId));
    check({tag, ".alu_bundle"},   alu_bundle,        mBundle);
  endtask

  vec_t          tbl[23];
  logic [BW-1:0] b0, b1, tExpB;
  logic [63:0]   rnd;
  logic [11:0]   rs0, rs1;

  function automatic vec_t mk(input logic rst, input logic fl, input logic v0, input logic v1,
                              input logic [11:0] s0, input logic [11:0] s1,
                              input logic r0, input logic r1, input logic val,
                              input logic id, input logic ill);
    vec_t t;
    t.rst = rst; t.fl = fl; t.v0 = v0; t.v1 = v1; t.s0 = s0; t.s1 = s1;
    t.r0 = r0; t.r1 = r1; t.val = val; t.id = id; t.ill = ill;
    return t;
  endfunction

  function automatic logic [11:0] randSig();
    int pick = int'($urandom_range(0, 9));
    if (pick < 2) return 12'h010;
    if (pick < 4) return 12'($urandom);
    return 12'(1) << $urandom_range(0, 11);
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_bundle = '0; req1_bundle = '0;

    tbl[0]  = mk(H,L,H,H,12'h001,12'h001, L,L,L,L,L);
    tbl[1]  = mk(L,L,H,H,12'h001,12'h001, H,L,H,L,L);
    tbl[2]  = mk(L,L,H,H,12'h001,12'h001, L,H,H,H,L);
    tbl[3]  = mk(L,L,H,H,12'h001,12'h001, H,L,H,L,L);
    tbl[4]  = mk(L,L,H,H,12'h001,12'h001, L,H,H,H,L);
    tbl[5]  = mk(L,L,H,H,12'h010,12'h001, H,L,H,L,L);
    tbl[6]  = mk(L,L,L,H,12'h000,12'h001, L,L,L,L,L);
    tbl[7]  = mk(L,L,L,H,12'h000,12'h001, L,L,L,L,L);
    tbl[8]  = mk(L,L,L,H,12'h000,12'h001, L,H,H,H,L);
    tbl[9]  = mk(L,L,L,H,12'h000,12'h003, L,H,L,H,H);
    tbl[10] = mk(L,L,H,H,12'h001,12'h001, H,L,H,L,L);
    tbl[11] = mk(L,H,H,L,12'h001,12'h000, L,L,L,L,L);
    tbl[12] = mk(L,L,H,L,12'h001,12'h000, H,L,H,L,L);
    tbl[13] = mk(L,L,H,L,12'h010,12'h000, H,L,H,L,L);
    tbl[14] = mk(L,L,H,H,12'h001,12'h001, L,L,L,L,L);
    tbl[15] = mk(H,L,H,H,12'h001,12'h001, L,L,L,L,L);
    tbl[16] = mk(L,L,H,H,12'h001,12'h001, H,L,H,L,L);
    tbl[17] = mk(L,L,H,L,12'h010,12'h000, H,L,H,L,L);
    tbl[18] = mk(L,H,H,H,12'h001,12'h001, L,L,L,L,L);
    tbl[19] = mk(L,L,H,H,12'h001,12'h001, L,H,H,H,L);
    tbl[20] = mk(H,H,H,H,12'h001,12'h001, L,L,L,L,L);
    tbl[21] = mk(L,L,H,L,12'h000,12'h000, H,L,L,L,H);
    tbl[22] = mk(L,L,H,H,12'h001,12'h001, L,H,H,H,L);

    tExpB = '0;
    for (int i = 0; i < 23; i++) begin
      b0 = mkBundle(54'(i * 2 + 1), tbl[i].s0);
      b1 = mkBundle(54'(i * 2 + 2), tbl[i].s1);
      applyStimulus(tbl[i].rst, tbl[i].fl, tbl[i].v0, b0, tbl[i].v1, b1);
      if (tbl[i].rst)      tExpB = '0;
      else if (tbl[i].val) tExpB = tbl[i].id ? b1 : b0;
      check($sformatf("vec%0d.req0_ready", i),   BW'(gotR0),        BW'(tbl[i].r0));
      check($sformatf("vec%0d.req1_ready", i),   BW'(gotR1),        BW'(tbl[i].r1));
      check($sformatf("vec%0d.alu_valid", i),    BW'(alu_valid),    BW'(tbl[i].val));
      check($sformatf("vec%0d.illegal_op", i),   BW'(illegal_op),   BW'(tbl[i].ill));
      check($sformatf("vec%0d.alu_grant_id", i), BW'(alu_grant_id), BW'(tbl[i].id));
      check($sformatf("vec%0d.alu_bundle", i),   alu_bundle,        tExpB);
    end

    // Lane 1 mul, then flush on the cycle the wait would have expired.
    applyStimulus(L, L, L, mkBundle(54'h100, 12'h001), H, mkBundle(54'h101, 12'h010));
    checkOutput("seqMul");
    applyStimulus(L, L, H, mkBundle(54'h102, 12'h001), H, mkBundle(54'h103, 12'h001));
    checkOutput("seqWait");
    applyStimulus(L, H, H, mkBundle(54'h102, 12'h001), H, mkBundle(54'h103, 12'h001));
    checkOutput("seqFlushExpiry");
    applyStimulus(L, L, H, mkBundle(54'h102, 12'h001), H, mkBundle(54'h103, 12'h001));
    checkOutput("seqResume");
    applyStimulus(L, L, H, mkBundle(54'h104, 12'h010), L, mkBundle(54'h105, 12'h001));
    checkOutput("seqMul2");
    applyStimulus(H, H, H, mkBundle(54'h106, 12'h001), H, mkBundle(54'h107, 12'h001));
    checkOutput("seqResetFlush");
    applyStimulus(L, L, H, mkBundle(54'h108, 12'h001), H, mkBundle(54'h109, 12'h001));
    checkOutput("seqAfterReset");

    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom, $urandom};
      rs0 = randSig();
      rs1 = randSig();
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 9) < 7), mkBundle(rnd[53:0], rs0),
                    ($urandom_range(0, 9) < 7), mkBundle(~rnd[53:0], rs1));
      checkOutput($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
